flash_read_ctrl: RTL

Read-only controller between the CPU's peripheral bus port and the board's 16-bit parallel NOR flash (x28fxxxp30-class).
- Converts a single-word bus request into two timed asynchronous halfword reads and assembles a 32-bit little-endian word.
- Drives the flash_* pins of intomips_top directly.
- Handles flash power-up by holding RP_N low for a fixed period after reset.

---
 rtl/flash_read_ctrl_pkg.sv | 23 ++
 rtl/flash_read_ctrl_if.sv | 27 ++
 rtl/flash_read_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/flash_read_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flash_read_ctrl_pkg : shared types and defaults for the flash read path
// Rev 1.0
// ---------------------------------------------------------------------------
package flash_read_ctrl_pkg;

    typedef logic [22:0] FlashAddr_t;
    typedef logic [15:0] FlashHalf_t;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        RD_LO = 3'd2,
        RD_HI = 3'd3,
        ACK   = 3'd4
    } flash_state_t;

    localparam int FLASH_WAIT_CYCLES = 6;
    localparam int FLASH_RP_CYCLES   = 16;

endpackage
`default_nettype wire

// File: rtl/flash_read_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flash_read_ctrl_if : CPU-side word read port of the flash controller
// Rev 1.0
// ---------------------------------------------------------------------------
interface flash_read_ctrl_if
    import flash_read_ctrl_pkg::*;
#(
    parameter int FLASH_ADDR_W = $bits(FlashAddr_t)
);
    logic                    bus_req;
    logic [FLASH_ADDR_W-1:0] bus_addr;
    logic                    bus_ack;
    logic [31:0]             bus_rdata;
    logic                    ready;

    modport master (
        output bus_req, bus_addr,
        input  bus_ack, bus_rdata, ready
    );

    modport slave (
        input  bus_req, bus_addr,
        output bus_ack, bus_rdata, ready
    );
endinterface
`default_nettype wire

// File: rtl/flash_read_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flash_read_ctrl : turns one word read into two timed NOR halfword reads
// Rev 1.0
// ---------------------------------------------------------------------------
module flash_read_ctrl
    import flash_read_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES  = FLASH_WAIT_CYCLES,
    parameter int RP_CYCLES    = FLASH_RP_CYCLES,
    parameter int FLASH_ADDR_W = $bits(FlashAddr_t)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    flash_read_ctrl_if.slave        bus,
    output logic [FLASH_ADDR_W-1:0] flash_a,
    inout  wire  [15:0]             flash_d,
    output logic                    flash_rp_n,
    output logic                    flash_vpen,
    output logic                    flash_ce_n,
    output logic                    flash_oe_n,
    output logic                    flash_we_n
);

    // One counter serves both the power-up hold and the per-half wait.
    localparam int CNT_MAX = (WAIT_CYCLES > RP_CYCLES) ? WAIT_CYCLES : RP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(RP_CYCLES - 1);

    flash_state_t              state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [FLASH_ADDR_W-1:1]   addr_q;
    FlashHalf_t                lo_q;
    logic                      ack_q;
    logic [31:0]               rdata_q;
    logic                      ready_q;
    logic                      rp_n_q;
    logic                      ce_n_q;
    logic                      unused_addr_lsbs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            addr_q  <= '0;
            lo_q    <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            rp_n_q  <= 1'b0;
            ce_n_q  <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                INIT: begin
                    if (cnt_q == RP_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        rp_n_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.bus_req) begin
                        state_q <= RD_LO;
                        cnt_q   <= WAIT_LAST;
                        addr_q  <= {bus.bus_addr[FLASH_ADDR_W-1:2], 1'b0};
                        ce_n_q  <= 1'b0;
                    end
                end
                RD_LO: begin
                    if (cnt_q == '0) begin
                        state_q   <= RD_HI;
                        cnt_q     <= WAIT_LAST;
                        lo_q      <= flash_d;
                        addr_q[1] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RD_HI: begin
                    // Register ack and data here so both are valid during ACK.
                    if (cnt_q == '0) begin
                        state_q <= ACK;
                        cnt_q   <= '0;
                        ack_q   <= 1'b1;
                        rdata_q <= {flash_d, lo_q};
                        ce_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign flash_a       = {addr_q, 1'b0};
    assign flash_ce_n    = ce_n_q;
    assign flash_oe_n    = ce_n_q;
    assign flash_rp_n    = rp_n_q;
    assign flash_vpen    = 1'b0;
    assign flash_we_n    = 1'b1;
    assign bus.bus_ack   = ack_q;
    assign bus.bus_rdata = rdata_q;
    assign bus.ready     = ready_q;

    assign unused_addr_lsbs = ^bus.bus_addr[1:0];

endmodule
`default_nettype wire
